// File: rtl/data_cache_2way_if.sv
// CPU load/store port and block memory port of the 2-way data cache.
interface data_cache_2way_if #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned OFFSET_W = 2
);
  logic                        read;
  logic                        write;
  logic [ADDR_W-1:0]           address;
  logic [7:0]                  writedata;
  logic [7:0]                  readdata;
  logic                        busywait;
  logic                        flush;
  logic                        flush_done;
  logic                        mem_read;
  logic                        mem_write;
  logic [ADDR_W-OFFSET_W-1:0]  mem_address;
  logic [8*(2**OFFSET_W)-1:0]  mem_writedata;
  logic [8*(2**OFFSET_W)-1:0]  mem_readdata;
  logic                        mem_busywait;

  // Environment side: CPU requests and memory responses.
  modport master (
    output read, write, address, writedata, flush, mem_readdata, mem_busywait,
    input  readdata, busywait, flush_done, mem_read, mem_write, mem_address, mem_writedata
  );

  // Cache side.
  modport slave (
    input  read, write, address, writedata, flush, mem_readdata, mem_busywait,
    output readdata, busywait, flush_done, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/data_cache_2way.sv
// 2-way set-associative write-back data cache with per-set LRU and flush.
module data_cache_2way #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned OFFSET_W = 2,
  parameter int unsigned INDEX_W  = 2
) (
  input logic              clk,
  input logic              reset_n,
  data_cache_2way_if.slave bus
);
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned SETS    = 2**INDEX_W;
  localparam int unsigned BYTES   = 2**OFFSET_W;
  localparam int unsigned BLOCK_W = 8 * BYTES;
  localparam int unsigned BADDR_W = ADDR_W - OFFSET_W;
  localparam int unsigned SCAN_W  = INDEX_W + 1;

  typedef enum logic [2:0] {StIdle, StWriteBack, StAllocate, StFlushScan, StFlushWb} state_e;

  state_e state_q, state_d;

  logic [TAG_W-1:0]   tag_q   [SETS][2];
  logic [BLOCK_W-1:0] data_q  [SETS][2];
  logic [1:0]         valid_q [SETS];
  logic [1:0]         dirty_q [SETS];
  logic [SETS-1:0]    lru_q;   // way to evict next in each set

  logic               mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [BADDR_W-1:0] mem_address_q, mem_address_d;
  logic [BLOCK_W-1:0] mem_writedata_q, mem_writedata_d;
  logic               victim_q, victim_d;
  logic [SCAN_W-1:0]  scan_q, scan_d;   // {set, way} flush pointer
  logic               flush_pending_q, flush_pending_d;
  logic               flush_done_q, flush_done_d;

  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  index;
  logic [OFFSET_W-1:0] offset;
  logic                req, hit0, hit1, hit, hit_way, victim_c, access_hit;
  logic                fill, clean_line;
  logic [INDEX_W-1:0]  scan_set;
  logic                scan_way;
  logic [7:0]          rdata;

  assign tag      = bus.address[ADDR_W-1 -: TAG_W];
  assign index    = bus.address[OFFSET_W +: INDEX_W];
  assign offset   = bus.address[OFFSET_W-1:0];
  assign req      = bus.read | bus.write;
  assign hit0     = valid_q[index][0] && (tag_q[index][0] == tag);
  assign hit1     = valid_q[index][1] && (tag_q[index][1] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign victim_c = !valid_q[index][0] ? 1'b0 : (!valid_q[index][1] ? 1'b1 : lru_q[index]);
  assign access_hit = (state_q == StIdle) && hit && req;
  assign scan_set = scan_q[SCAN_W-1:1];
  assign scan_way = scan_q[0];

  assign bus.busywait      = (req && !((state_q == StIdle) && hit)) || (state_q != StIdle);
  assign bus.readdata      = rdata;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;
  assign bus.flush_done    = flush_done_q;

  // Byte select from the hitting way; zero when nothing hits.
  always_comb begin
    rdata = 8'h00;
    if (hit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (offset == OFFSET_W'(b)) rdata = data_q[index][hit_way][8*b +: 8];
      end
    end
  end

  // Next-state, registered memory request values and array update strobes.
  always_comb begin
    state_d         = state_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    victim_d        = victim_q;
    scan_d          = scan_q;
    flush_done_d    = 1'b0;
    fill            = 1'b0;
    clean_line      = 1'b0;
    // A flush seen while a flush is already running is dropped.
    flush_pending_d = flush_pending_q |
                      (bus.flush && (state_q != StFlushScan) && (state_q != StFlushWb));
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (!hit) begin
            victim_d = victim_c;
            if (valid_q[index][victim_c] && dirty_q[index][victim_c]) begin
              state_d         = StWriteBack;
              mem_write_d     = 1'b1;
              mem_address_d   = {tag_q[index][victim_c], index};
              mem_writedata_d = data_q[index][victim_c];
            end else begin
              state_d       = StAllocate;
              mem_read_d    = 1'b1;
              mem_address_d = {tag, index};
            end
          end
        end else if (bus.flush || flush_pending_q) begin
          state_d         = StFlushScan;
          scan_d          = '0;
          flush_pending_d = 1'b0;
        end
      end
      StWriteBack: begin
        if (!bus.mem_busywait) begin
          state_d       = StAllocate;
          mem_write_d   = 1'b0;
          mem_read_d    = 1'b1;
          mem_address_d = {tag, index};
        end
      end
      StAllocate: begin
        if (!bus.mem_busywait) begin
          state_d    = StIdle;
          mem_read_d = 1'b0;
          fill       = 1'b1;
        end
      end
      StFlushScan: begin
        if (valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way]) begin
          state_d         = StFlushWb;
          mem_write_d     = 1'b1;
          mem_address_d   = {tag_q[scan_set][scan_way], scan_set};
          mem_writedata_d = data_q[scan_set][scan_way];
        end else if (&scan_q) begin
          state_d      = StIdle;
          flush_done_d = 1'b1;
        end else begin
          scan_d = scan_q + SCAN_W'(1);
        end
      end
      StFlushWb: begin
        if (!bus.mem_busywait) begin
          mem_write_d = 1'b0;
          clean_line  = 1'b1;
          if (&scan_q) begin
            state_d      = StIdle;
            flush_done_d = 1'b1;
          end else begin
            state_d = StFlushScan;
            scan_d  = scan_q + SCAN_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered memory interface; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      victim_q        <= 1'b0;
      scan_q          <= '0;
      flush_pending_q <= 1'b0;
      flush_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      victim_q        <= victim_d;
      scan_q          <= scan_d;
      flush_pending_q <= flush_pending_d;
      flush_done_q    <= flush_done_d;
    end
  end

  // Valid, dirty and LRU bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 2'b00;
        dirty_q[s] <= 2'b00;
      end
      lru_q <= '0;
    end else begin
      if (access_hit) begin
        lru_q[index] <= ~hit_way;
        if (bus.write) dirty_q[index][hit_way] <= 1'b1;
      end
      if (fill) begin
        valid_q[index][victim_q] <= 1'b1;
        dirty_q[index][victim_q] <= 1'b0;
      end
      if (clean_line) dirty_q[scan_set][scan_way] <= 1'b0;
    end
  end

  // Tag and data storage; contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (access_hit && bus.write) begin
      for (int b = 0; b < BYTES; b++) begin
        if (offset == OFFSET_W'(b)) data_q[index][hit_way][8*b +: 8] <= bus.writedata;
      end
    end
    if (fill) begin
      data_q[index][victim_q] <= bus.mem_readdata;
      tag_q[index][victim_q]  <= tag;
    end
  end
endmodule

// File: tb/tb_data_cache_2way.sv
// Directed self-checking bench for data_cache_2way with a 5-cycle block memory.
module tb_data_cache_2way;
  localparam int LAT = 5;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  data_cache_2way_if #(.ADDR_W(8), .OFFSET_W(2)) bus ();

  data_cache_2way #(.ADDR_W(8), .OFFSET_W(2), .INDEX_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block memory: busy for LAT cycles after a request appears, then completes.
  logic [31:0] mem [64];
  int          cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [5:0]  last_rd_addr = '0;
  logic [5:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (cnt != LAT);
  assign bus.mem_readdata = mem[bus.mem_address];

  always @(posedge clk) begin
    if (!reset_n) begin
      cnt <= 0;
    end else if (bus.mem_read || bus.mem_write) begin
      if (cnt == LAT) begin
        cnt <= 0;
        if (bus.mem_write) begin
          mem[bus.mem_address] <= bus.mem_writedata;
          wr_cnt       <= wr_cnt + 1;
          last_wr_addr <= bus.mem_address;
          last_wr_data <= bus.mem_writedata;
        end else begin
          rd_cnt       <= rd_cnt + 1;
          last_rd_addr <= bus.mem_address;
        end
      end else begin
        cnt <= cnt + 1;
      end
    end
    if (bus.flush_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU access held until busywait drops, then completed on the next posedge.
  task automatic cpu_access(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                            output logic [7:0] rd, output int stalls);
    @(negedge clk);
    bus.address   = a;
    bus.writedata = wd;
    bus.read      = !wr;
    bus.write     = wr;
    stalls = 0;
    #1;
    while (bus.busywait && stalls < 200) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (stalls >= 200) check("access_timeout", 32'(stalls), 32'd0);
    rd = bus.readdata;
    @(posedge clk);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  logic [7:0] rd;
  int         st;
  int         w0;
  int         r0;
  int         d0;
  int         cyc;
  logic       done;

  initial begin
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 4; j++)
        mem[i][8*j +: 8] = 8'(i*4 + j) ^ 8'h5A;
    reset_n = 1'b0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.address = '0;
    bus.writedata = '0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_busywait", 32'(bus.busywait), 32'd0);
    check("rst_flush_done", 32'(bus.flush_done), 32'd0);
    check("rst_mem_address", 32'(bus.mem_address), 32'd0);
    check("rst_readdata", 32'(bus.readdata), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Cold read miss into set 0.
    cpu_access(1'b0, 8'h00, 8'h00, rd, st);
    check("miss00_stalled", 32'(st != 0), 32'd1);
    check("miss00_data", 32'(rd), 32'h5A);
    check("miss00_reads", 32'(rd_cnt), 32'd1);
    check("miss00_rd_addr", 32'(last_rd_addr), 32'h00);

    // Same set, different tag: fills way 1 without any write-back.
    cpu_access(1'b0, 8'h20, 8'h00, rd, st);
    check("miss20_data", 32'(rd), 32'h7A);
    check("miss20_rd_addr", 32'(last_rd_addr), 32'h08);
    cpu_access(1'b0, 8'h00, 8'h00, rd, st);
    check("rehit00_stall", 32'(st), 32'd0);
    check("rehit00_data", 32'(rd), 32'h5A);
    cpu_access(1'b0, 8'h20, 8'h00, rd, st);
    check("rehit20_stall", 32'(st), 32'd0);
    check("no_writeback", 32'(wr_cnt), 32'd0);

    // Dirty LRU victim is written back before the new block is fetched.
    cpu_access(1'b1, 8'h00, 8'hAA, rd, st);
    check("write00_hit_stall", 32'(st), 32'd0);
    cpu_access(1'b0, 8'h20, 8'h00, rd, st);
    cpu_access(1'b0, 8'h40, 8'h00, rd, st);
    check("wb_count", 32'(wr_cnt), 32'd1);
    check("wb_addr", 32'(last_wr_addr), 32'h00);
    check("wb_byte0", 32'(last_wr_data[7:0]), 32'hAA);
    check("wb_byte1", 32'(last_wr_data[15:8]), 32'h5B);
    check("refill_addr", 32'(last_rd_addr), 32'h10);
    check("miss40_data", 32'(rd), 32'h1A);

    // Zero-stall read hits across every byte offset.
    for (int k = 0; k < 4; k++) begin
      cpu_access(1'b0, 8'(8'h40 + k), 8'h00, rd, st);
      check("hit_off_stall", 32'(st), 32'd0);
      check("hit_off_data", 32'(rd), 32'((8'h40 + 8'(k)) ^ 8'h5A));
    end

    // Dirty lines in sets 1 and 3, then flush.
    cpu_access(1'b1, 8'h04, 8'h11, rd, st);
    cpu_access(1'b1, 8'h0C, 8'h33, rd, st);
    w0 = wr_cnt;
    d0 = done_cnt;
    @(negedge clk);
    bus.flush = 1'b1;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      bus.flush = 1'b0;
      if (bus.flush_done) done = 1'b1;
    end
    check("flush_done_seen", 32'(done), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("flush_writes", 32'(wr_cnt - w0), 32'd2);
    check("flush_done_once", 32'(done_cnt - d0), 32'd1);
    check("flush_mem_set1", 32'(mem[1][7:0]), 32'h11);
    check("flush_mem_set3", 32'(mem[3][7:0]), 32'h33);

    // Everything clean now: a second flush only scans all eight lines.
    w0 = wr_cnt;
    @(negedge clk);
    bus.flush = 1'b1;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      bus.flush = 1'b0;
      if (bus.flush_done) done = 1'b1;
    end
    check("flush_clean_cycles", 32'(cyc), 32'd9);
    check("flush_clean_writes", 32'(wr_cnt - w0), 32'd0);

    // Flushed lines stay resident and are now clean.
    cpu_access(1'b0, 8'h04, 8'h00, rd, st);
    check("post_flush_hit04_stall", 32'(st), 32'd0);
    check("post_flush_hit04_data", 32'(rd), 32'h11);
    cpu_access(1'b0, 8'h0C, 8'h00, rd, st);
    check("post_flush_hit0c_data", 32'(rd), 32'h33);
    w0 = wr_cnt;
    cpu_access(1'b0, 8'h14, 8'h00, rd, st);
    cpu_access(1'b0, 8'h24, 8'h00, rd, st);
    check("clean_evict_no_wb", 32'(wr_cnt - w0), 32'd0);
    check("miss24_data", 32'(rd), 32'h7E);

    // Reset in the middle of a write-back.
    cpu_access(1'b1, 8'h08, 8'h77, rd, st);
    cpu_access(1'b0, 8'h28, 8'h00, rd, st);
    w0 = wr_cnt;
    @(negedge clk);
    bus.address = 8'h48;
    bus.read    = 1'b1;
    @(posedge clk);
    #1;
    check("wb_started", 32'(bus.mem_write), 32'd1);
    check("wb_started_addr", 32'(bus.mem_address), 32'h02);
    @(negedge clk);
    reset_n  = 1'b0;
    bus.read = 1'b0;
    @(posedge clk);
    #1;
    check("rst_wb_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_wb_busywait", 32'(bus.busywait), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    r0 = rd_cnt;
    cpu_access(1'b0, 8'h08, 8'h00, rd, st);
    check("rst_line_invalid", 32'(st != 0), 32'd1);
    check("rst_refetch", 32'(rd_cnt - r0), 32'd1);
    check("rst_refetch_data", 32'(rd), 32'h52);
    check("rst_wb_abandoned", 32'(wr_cnt - w0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
